// File: rtl/multi_player_press_counter.sv
// Button-press race for NUM_PLAYERS players over a timed round with a countdown bar.
// Per-player edge-counted, saturating counters with an equalize-to-leader request.
module multi_player_press_counter #(
  parameter int unsigned NUM_PLAYERS      = 4,
  parameter int unsigned COUNT_WIDTH      = 10,
  parameter int unsigned ROUND_SECONDS    = 10,
  parameter int unsigned TICKS_PER_SECOND = 50_000_000,
  localparam int unsigned IDX_W = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int unsigned SEC_W = $clog2(ROUND_SECONDS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               activator,
  input  logic [NUM_PLAYERS-1:0]             buttons,
  input  logic [NUM_PLAYERS-1:0]             equalizer,
  output logic [NUM_PLAYERS*COUNT_WIDTH-1:0] counts,
  output logic [ROUND_SECONDS-1:0]           indicator,
  output logic                               busy,
  output logic [IDX_W-1:0]                   winner,
  output logic                               winner_valid,
  output logic                               tie
);

  localparam int unsigned TICK_W =
      ($clog2(TICKS_PER_SECOND) > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [COUNT_WIDTH-1:0] CntMax   = '1;
  localparam logic [TICK_W-1:0]      TickLast = TICK_W'(TICKS_PER_SECOND - 1);
  localparam logic [SEC_W-1:0]       SecInit  = SEC_W'(ROUND_SECONDS);

  typedef enum logic [1:0] {StIdle, StCounting, StResult} state_e;

  state_e                   state_q, state_d;
  logic [NUM_PLAYERS-1:0]   btn_q;
  logic [COUNT_WIDTH-1:0]   cnt_q [NUM_PLAYERS];
  logic [COUNT_WIDTH-1:0]   cnt_d [NUM_PLAYERS];
  logic [COUNT_WIDTH-1:0]   inc   [NUM_PLAYERS];
  logic [COUNT_WIDTH-1:0]   lead;
  logic [TICK_W-1:0]        tick_q, tick_d;
  logic [SEC_W-1:0]         sec_left_q, sec_left_d;
  logic [ROUND_SECONDS-1:0] indicator_q, indicator_d;
  logic                     busy_q;
  logic [NUM_PLAYERS-1:0]   press;
  logic                     tick_wrap;

  logic [COUNT_WIDTH-1:0]   max_val;
  logic [IDX_W-1:0]         win_idx;
  logic                     found;
  logic                     multi;

  assign press     = buttons & ~btn_q;
  assign tick_wrap = (tick_q == TickLast);

  // Post-press values and the leader they produce; equalize loads this same leader.
  always_comb begin
    lead = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      inc[i] = (press[i] && (cnt_q[i] != CntMax)) ? cnt_q[i] + COUNT_WIDTH'(1) : cnt_q[i];
      if (inc[i] > lead) begin
        lead = inc[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    sec_left_d  = sec_left_q;
    indicator_d = indicator_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (activator) begin
          state_d = StCounting;
        end
      end
      StCounting: begin
        if (!activator) begin
          state_d = StIdle;
        end else begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            cnt_d[i] = equalizer[i] ? lead : inc[i];
          end
          if (tick_wrap) begin
            tick_d     = '0;
            sec_left_d = sec_left_q - SEC_W'(1);
            for (int j = 0; j < ROUND_SECONDS; j++) begin
              if (SEC_W'(j + 1) == sec_left_q) begin
                indicator_d[j] = 1'b0;
              end
            end
            if (sec_left_q == SEC_W'(1)) begin
              state_d = StResult;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      StResult: begin
        if (!activator) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Entering or sitting in IDLE always presents a fresh round.
    if ((state_q == StIdle) || (state_d == StIdle)) begin
      tick_d      = '0;
      sec_left_d  = SecInit;
      indicator_d = '1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      btn_q       <= '0;
      tick_q      <= '0;
      sec_left_q  <= SecInit;
      indicator_q <= '1;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      btn_q       <= buttons;
      tick_q      <= tick_d;
      sec_left_q  <= sec_left_d;
      indicator_q <= indicator_d;
      busy_q      <= (state_d == StCounting);
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Lowest index holding the maximum; multi flags a shared maximum.
  always_comb begin
    max_val = '0;
    win_idx = '0;
    found   = 1'b0;
    multi   = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (cnt_q[i] > max_val) begin
        max_val = cnt_q[i];
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (cnt_q[i] == max_val) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          win_idx = IDX_W'(i);
        end
        found = 1'b1;
      end
    end
  end

  genvar g;
  for (g = 0; g < NUM_PLAYERS; g++) begin : g_counts
    assign counts[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[g];
  end

  assign indicator    = indicator_q;
  assign busy         = busy_q;
  assign winner       = (state_q == StResult) ? win_idx : '0;
  assign winner_valid = (state_q == StResult) && !multi;
  assign tie          = (state_q == StResult) && multi;

endmodule
